// File: rtl/ula_serial_ctrl_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The master side issues START with operands; the slave side returns BUSY/DONE and the result.
interface ula_serial_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start_i;
  logic [3:0]       aluctl_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;

  modport master (
    output start_i, aluctl_i, a_i, b_i,
    input  busy_o, done_o, result_o, zero_o, overflow_o
  );

  modport slave (
    input  start_i, aluctl_i, a_i, b_i,
    output busy_o, done_o, result_o, zero_o, overflow_o
  );
endinterface

// File: rtl/ula_serial_ctrl.sv
// Bit-serial ALU: one 1-bit slice stepped LSB first over WIDTH bits with a held carry,
// followed by a finish cycle that applies SLT, ZERO and OVERFLOW.
module ula_serial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  ula_serial_ctrl_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             lovf_q, lovf_d;
  logic             set_q, set_d;

  logic             ainv_c, binv_c, valid_c, is_arith_c, is_slt_c, cin_start_c;
  logic [1:0]       op_c;
  logic             bit_a_c, bit_b_c, sum_c, cout_c, res_bit_c;
  logic [WIDTH-1:0] fin_result_c;

  // Decode of the latched operation; CIN is decoded from the live request at acceptance
  always_comb begin
    ainv_c     = 1'b0;
    binv_c     = 1'b0;
    op_c       = 2'b00;
    valid_c    = 1'b1;
    case (ctl_q)
      CTL_AND: op_c = 2'b00;
      CTL_OR:  op_c = 2'b01;
      CTL_ADD: op_c = 2'b10;
      CTL_SUB: begin binv_c = 1'b1; op_c = 2'b10; end
      CTL_SLT: begin binv_c = 1'b1; op_c = 2'b11; end
      CTL_NOR: begin ainv_c = 1'b1; binv_c = 1'b1; op_c = 2'b00; end
      default: valid_c = 1'b0;
    endcase
    is_arith_c  = (ctl_q == CTL_ADD) || (ctl_q == CTL_SUB);
    is_slt_c    = (ctl_q == CTL_SLT);
    cin_start_c = (bus.aluctl_i == CTL_SUB) || (bus.aluctl_i == CTL_SLT);
  end

  // The 1-bit slice for the current bit position
  always_comb begin
    bit_a_c = a_q[cnt_q] ^ ainv_c;
    bit_b_c = b_q[cnt_q] ^ binv_c;
    sum_c   = bit_a_c ^ bit_b_c ^ carry_q;
    cout_c  = (bit_a_c & bit_b_c) | (bit_a_c & carry_q) | (bit_b_c & carry_q);
    case (op_c)
      2'b00:   res_bit_c = bit_a_c & bit_b_c;
      2'b01:   res_bit_c = bit_a_c | bit_b_c;
      2'b10:   res_bit_c = sum_c;
      default: res_bit_c = 1'b0;
    endcase
    if (!valid_c) res_bit_c = 1'b0;

    if (!valid_c)      fin_result_c = '0;
    else if (is_slt_c) fin_result_c = WIDTH'(set_q);
    else               fin_result_c = result_q;
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    lovf_d   = lovf_q;
    set_d    = set_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          ctl_d   = bus.aluctl_i;
          carry_d = cin_start_c;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[cnt_q] = res_bit_c;
        carry_d         = cout_c;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Overflow is carry-in xor carry-out of the MSB; set corrects the sign on overflow
          lovf_d  = carry_q ^ cout_c;
          set_d   = sum_c ^ (carry_q ^ cout_c);
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        result_d = fin_result_c;
        zero_d   = (fin_result_c == '0);
        ovf_d    = is_arith_c & lovf_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      lovf_q   <= 1'b0;
      set_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      lovf_q   <= lovf_d;
      set_q    <= set_d;
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = ovf_q;
endmodule
